axi_cdc_isolate_ctrl: RTL
=========================

Name: axi_cdc_isolate_ctrl

Overview:
Single-clock isolation controller placed on the source side of an AXI clock-domain crossing. It lets a power/clock manager quiesce the crossing before the far domain is gated or reset. On request it stops new AW/AR issue, drains in-flight transactions, then reports the link isolated. It also caps outstanding transactions and flags drains that take too long.

Parameters:
MaxTxns, 8, max outstanding writes and max outstanding reads (separate counters); >=1
TimeoutCycles, 1024, drain cycles before drain_timeout_o is set; 0 disables the timeout
axi_req_t, logic, AXI request struct (aw/w/ar channels, valids, b_ready/r_ready)
axi_resp_t, logic, AXI response struct (b/r channels, readies, b_valid/r_valid)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
isolate_i  in  1  level request to isolate (1) or reconnect (0)
isolated_o  out  1  link quiesced; far side may be gated
drain_timeout_o  out  1  sticky, drain exceeded TimeoutCycles
wr_outstanding_o  out  $clog2(MaxTxns+1)  writes with AW accepted and B not yet accepted
rd_outstanding_o  out  $clog2(MaxTxns+1)  reads with AR accepted and R last not yet accepted
slv_req_i  in  axi_req_t  upstream request
slv_resp_o  out  axi_resp_t  upstream response
mst_req_o  out  axi_req_t  request toward the CDC
mst_resp_i  in  axi_resp_t  response from the CDC

Behaviour:
- Reset values: state RUN, both counters 0, isolated_o=0, drain_timeout_o=0, timeout counter 0, pending flags 0.
- Pass-through: all payloads, W, B and R channels are combinational pass-through. Only AW/AR valid and ready are gated. Zero added latency.
- Handshake events:
  - aw_hs = mst aw_valid & aw_ready; b_hs = b_valid & b_ready.
  - ar_hs = mst ar_valid & ar_ready; rl_hs = r_valid & r_ready & r.last.
- Counters:
  - wr += aw_hs, wr -= b_hs; aw_hs and b_hs in the same cycle leave it unchanged. Same rule for rd with ar_hs/rl_hs.
  - Counters never wrap. A decrement at 0 is a protocol error, flagged by a simulation-only assertion, and the counter holds.
- aw_pending register: set when mst aw_valid=1 and aw_ready=0; cleared on aw_hs. ar_pending works the same way.
- AW gating: aw_allow = (state==RUN and wr<MaxTxns) or aw_pending.
  - mst aw_valid = slv aw_valid & aw_allow; slv aw_ready = mst aw_ready & aw_allow.
  - AR is gated identically using rd and ar_pending.
  - A valid already presented downstream is never withdrawn (AXI stability).
- FSM states: RUN, DRAIN, ISOLATED.
  - RUN -> DRAIN when isolate_i=1.
  - DRAIN -> ISOLATED when wr==0, rd==0, !aw_pending and !ar_pending, evaluated on next-state counter values.
  - DRAIN -> RUN when isolate_i=0; the timeout counter clears and drain_timeout_o keeps its value.
  - ISOLATED -> RUN when isolate_i=0.
  - A request and a deassertion never cross in one cycle: the FSM samples isolate_i once per cycle.
- isolated_o: registered, equals (state==ISOLATED); asserted the cycle after the drain condition holds. In ISOLATED, AW/AR stay blocked and upstream sees aw_ready=ar_ready=0.
- Drain with nothing outstanding: DRAIN lasts exactly 1 cycle, so isolated_o rises 2 cycles after isolate_i rises.
- Timeout:
  - The timeout counter increments each cycle in DRAIN and saturates at TimeoutCycles.
  - On reaching TimeoutCycles, drain_timeout_o is set and stays set until reset. The FSM stays in DRAIN; there is no forced completion.
- Reset mid-operation asynchronously returns to RUN with all state cleared. The system must reset both CDC halves together.

Test Plan:
- Idle isolate: isolate_i 0->1 at cycle 0 with no traffic -> DRAIN in cycle 1, isolated_o=1 at cycle 2; isolate_i=0 -> isolated_o=0 next cycle, AW passes again.
- Write drain: 3 AWs accepted (wr=3), then isolate_i=1; new AW is held off (slv aw_ready=0); return 3 Bs -> wr 3->0, isolated_o rises the cycle after the last b_hs.
- Pending AW: AW valid held with aw_ready=0, then isolate_i=1 -> mst aw_valid stays 1 until aw_ready=1; then wr=1, and isolated_o follows only after the B returns.
- Read burst: AR len=3, isolate_i=1 -> rd stays 1 through non-last beats and drops to 0 on the R last beat; isolated_o follows.
- Saturation and simultaneous events: MaxTxns=2 with 2 writes outstanding -> AW blocked; aw_hs and b_hs in the same cycle -> wr unchanged at 1.
- Timeout: TimeoutCycles=16 with a B never returned -> drain_timeout_o=1 after 16 DRAIN cycles and isolated_o stays 0; deassert isolate_i -> RUN, drain_timeout_o remains 1 until rst_ni.

Source files
------------

// File: rtl/axi_cdc_isolate_ctrl.sv
// rtl/axi_cdc_isolate_ctrl.sv - source-side AXI CDC isolation controller (quiesce, drain, isolate)

package axi_cdc_isolate_pkg;
    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
    } ax_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } w_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } b_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } r_t;

    typedef struct packed {
        ax_t  aw;
        logic aw_valid;
        w_t   w;
        logic w_valid;
        logic b_ready;
        ax_t  ar;
        logic ar_valid;
        logic r_ready;
    } req_t;

    typedef struct packed {
        logic aw_ready;
        logic ar_ready;
        logic w_ready;
        b_t   b;
        logic b_valid;
        r_t   r;
        logic r_valid;
    } resp_t;
endpackage

module axi_cdc_isolate_ctrl #(
    parameter int unsigned MaxTxns       = 8,
    parameter int unsigned TimeoutCycles = 1024,
    parameter type axi_req_t             = axi_cdc_isolate_pkg::req_t,
    parameter type axi_resp_t            = axi_cdc_isolate_pkg::resp_t,
    localparam int unsigned CW           = $clog2(MaxTxns + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          isolate_i,
    output logic          isolated_o,
    output logic          drain_timeout_o,
    output logic [CW-1:0] wr_outstanding_o,
    output logic [CW-1:0] rd_outstanding_o,
    input  axi_req_t      slv_req_i,
    output axi_resp_t     slv_resp_o,
    output axi_req_t      mst_req_o,
    input  axi_resp_t     mst_resp_i
);

    localparam int unsigned TW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
    localparam logic [CW-1:0] MaxCnt = CW'(MaxTxns);
    localparam logic [TW-1:0] TmoMax = TW'(TimeoutCycles);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        DRAIN    = 2'd1,
        ISOLATED = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic          aw_pending_q, aw_pending_d, ar_pending_q, ar_pending_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          tmo_flag_q, tmo_flag_d;
    logic          aw_allow, ar_allow;
    logic          aw_hs, b_hs, ar_hs, rl_hs;
    logic          drained;

    // A pending address phase keeps its grant so a presented valid is never withdrawn.
    assign aw_allow = ((state_q == RUN) && (wr_q < MaxCnt)) || aw_pending_q;
    assign ar_allow = ((state_q == RUN) && (rd_q < MaxCnt)) || ar_pending_q;

    always_comb begin
        mst_req_o           = slv_req_i;
        mst_req_o.aw_valid  = slv_req_i.aw_valid & aw_allow;
        mst_req_o.ar_valid  = slv_req_i.ar_valid & ar_allow;
        slv_resp_o          = mst_resp_i;
        slv_resp_o.aw_ready = mst_resp_i.aw_ready & aw_allow;
        slv_resp_o.ar_ready = mst_resp_i.ar_ready & ar_allow;
    end

    assign aw_hs = mst_req_o.aw_valid & mst_resp_i.aw_ready;
    assign ar_hs = mst_req_o.ar_valid & mst_resp_i.ar_ready;
    assign b_hs  = mst_resp_i.b_valid & slv_req_i.b_ready;
    assign rl_hs = mst_resp_i.r_valid & slv_req_i.r_ready & mst_resp_i.r.last;

    always_comb begin
        wr_d = wr_q;
        if (aw_hs && !b_hs && (wr_q != MaxCnt)) begin
            wr_d = wr_q + CW'(1);
        end else if (b_hs && !aw_hs && (wr_q != '0)) begin
            wr_d = wr_q - CW'(1);
        end

        rd_d = rd_q;
        if (ar_hs && !rl_hs && (rd_q != MaxCnt)) begin
            rd_d = rd_q + CW'(1);
        end else if (rl_hs && !ar_hs && (rd_q != '0)) begin
            rd_d = rd_q - CW'(1);
        end

        aw_pending_d = aw_pending_q;
        if (aw_hs) begin
            aw_pending_d = 1'b0;
        end else if (mst_req_o.aw_valid) begin
            aw_pending_d = 1'b1;
        end

        ar_pending_d = ar_pending_q;
        if (ar_hs) begin
            ar_pending_d = 1'b0;
        end else if (mst_req_o.ar_valid) begin
            ar_pending_d = 1'b1;
        end
    end

    // Judged on next-state values so isolation follows the final response by one cycle.
    assign drained = (wr_d == '0) && (rd_d == '0) && !aw_pending_d && !ar_pending_d;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (isolate_i) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!isolate_i) begin
                    state_d = RUN;
                end else if (drained) begin
                    state_d = ISOLATED;
                end
            end
            ISOLATED: begin
                if (!isolate_i) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        tmo_d      = '0;
        tmo_flag_d = tmo_flag_q;
        if (state_q == DRAIN) begin
            tmo_d = tmo_q;
            if ((TimeoutCycles != 0) && (tmo_q != TmoMax)) begin
                tmo_d = tmo_q + TW'(1);
            end
            if ((TimeoutCycles != 0) && (tmo_d == TmoMax)) begin
                tmo_flag_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= RUN;
            wr_q         <= '0;
            rd_q         <= '0;
            aw_pending_q <= 1'b0;
            ar_pending_q <= 1'b0;
            tmo_q        <= '0;
            tmo_flag_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_q         <= wr_d;
            rd_q         <= rd_d;
            aw_pending_q <= aw_pending_d;
            ar_pending_q <= ar_pending_d;
            tmo_q        <= tmo_d;
            tmo_flag_q   <= tmo_flag_d;
        end
    end

    assign isolated_o       = (state_q == ISOLATED);
    assign drain_timeout_o  = tmo_flag_q;
    assign wr_outstanding_o = wr_q;
    assign rd_outstanding_o = rd_q;

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            assert (!(b_hs && !aw_hs && (wr_q == '0)))
                else $error("B response with no write outstanding");
            assert (!(rl_hs && !ar_hs && (rd_q == '0)))
                else $error("R last with no read outstanding");
        end
    end
`endif

endmodule
